// File: rtl/spi_fsm_defs.sv
// Shared definitions for the SPI memory transaction controller: state
// encodings, protocol constants and small state-classification helpers.
package spi_fsm_defs;

    // Protocol constants: 7 address bits + 1 R/W bit, then one data byte.
    localparam int   CMD_BITS  = 8;
    localparam int   DATA_BITS = 8;
    localparam logic RW_READ   = 1'b1;

    // 4-bit state encodings (kept as plain constants for legacy tools).
    localparam logic [3:0] ST_IDLE         = 4'd0;
    localparam logic [3:0] ST_GET_CMD      = 4'd1;
    localparam logic [3:0] ST_GOT_CMD      = 4'd2;
    localparam logic [3:0] ST_READ_WAIT    = 4'd3;
    localparam logic [3:0] ST_READ_LOAD    = 4'd4;
    localparam logic [3:0] ST_READ_SEND    = 4'd5;
    localparam logic [3:0] ST_WRITE_RECV   = 4'd6;
    localparam logic [3:0] ST_WRITE_COMMIT = 4'd7;
    localparam logic [3:0] ST_DONE         = 4'd8;

    // States in which an SCLK edge advances the edge counter.
    function automatic logic counting_state(input logic [3:0] st);
        logic r_is;
        case (st)
            ST_GET_CMD, ST_WRITE_RECV, ST_READ_SEND: r_is = 1'b1;
            default:                                 r_is = 1'b0;
        endcase
        return r_is;
    endfunction

    // States between the start of the command frame and the data commit;
    // a chip-select release here is a genuine abort.
    function automatic logic in_transaction(input logic [3:0] st);
        logic r_is;
        case (st)
            ST_GET_CMD, ST_GOT_CMD, ST_READ_WAIT, ST_READ_LOAD,
            ST_READ_SEND, ST_WRITE_RECV, ST_WRITE_COMMIT: r_is = 1'b1;
            default:                                       r_is = 1'b0;
        endcase
        return r_is;
    endfunction

endpackage

// File: rtl/edge_counter.sv
// Frame edge counter. Counts enable pulses, clears synchronously, and flags
// the pulse that brings the count up to the terminal value.
module edge_counter #(
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [width-1:0] i_term,
    output logic [width-1:0] o_count,
    output logic             o_hit
);

    logic [width-1:0] r_count;

    assign o_count = r_count;
    // Combinational so the FSM can leave the counting state on the very
    // edge that completes the frame.
    assign o_hit   = i_en && ((r_count + width'(1)) == i_term);

    // Count register: clear has priority over counting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + width'(1);
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/spi_fsm.sv
// SPI memory transaction controller. Sequences one command frame and one
// data frame per chip-select assertion and issues the datapath enables as
// registered Moore outputs.
// Optional feature: define SPI_FSM_ABORT_FLAG_EN to add the 'abort' pulse
// output (one cycle after chip select is released mid-transaction).
module spi_fsm
    import spi_fsm_defs::*;
#(
    parameter int cmdbits    = CMD_BITS,
    parameter int databits   = DATA_BITS,
    parameter int countwidth = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic cs_n,
    input  logic sclk_pos,
    input  logic sclk_neg,
    input  logic rw_bit,
    output logic addr_we,
    output logic sr_we,
    output logic dm_we,
    output logic miso_bufe
`ifdef SPI_FSM_ABORT_FLAG_EN
    ,
    output logic abort
`endif
);

    localparam logic [countwidth-1:0] CMD_TERM  = countwidth'(cmdbits);
    localparam logic [countwidth-1:0] DATA_TERM = countwidth'(databits);

    logic [3:0]            r_state;
    logic [3:0]            w_next_state;
    logic                  w_cnt_en;
    logic                  w_clear;
    logic                  w_hit;
    logic                  w_count_bad;
    logic [countwidth-1:0] w_term;
    logic [countwidth-1:0] w_count;
    logic                  r_addr_we;
    logic                  r_sr_we;
    logic                  r_dm_we;
    logic                  r_miso_bufe;

    // Pick the SCLK edge polarity counted in this state and its frame length
    always_comb begin
        w_cnt_en = 1'b0;
        w_term   = CMD_TERM;
        case (r_state)
            ST_GET_CMD: begin
                w_cnt_en = sclk_pos;
                w_term   = CMD_TERM;
            end
            ST_WRITE_RECV: begin
                w_cnt_en = sclk_pos;
                w_term   = DATA_TERM;
            end
            ST_READ_SEND: begin
                w_cnt_en = sclk_neg;
                w_term   = DATA_TERM;
            end
            default: begin
                w_cnt_en = 1'b0;
                w_term   = CMD_TERM;
            end
        endcase
    end

    // A count at or beyond the frame length can only come from an upset;
    // treat it as an abort to the safe IDLE state.
    assign w_count_bad = counting_state(r_state) && (w_count >= w_term);

    // Next-state logic; chip-select release overrides every other transition
    always_comb begin
        w_next_state = r_state;
        if ((r_state != ST_IDLE) && cs_n) begin
            w_next_state = ST_IDLE;
        end else if (w_count_bad) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!cs_n) begin
                        w_next_state = ST_GET_CMD;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
                ST_GET_CMD: begin
                    if (w_hit) begin
                        w_next_state = ST_GOT_CMD;
                    end else begin
                        w_next_state = ST_GET_CMD;
                    end
                end
                ST_GOT_CMD: begin
                    if (rw_bit == RW_READ) begin
                        w_next_state = ST_READ_WAIT;
                    end else begin
                        w_next_state = ST_WRITE_RECV;
                    end
                end
                ST_READ_WAIT:    w_next_state = ST_READ_LOAD;
                ST_READ_LOAD:    w_next_state = ST_READ_SEND;
                ST_READ_SEND: begin
                    if (w_hit) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_READ_SEND;
                    end
                end
                ST_WRITE_RECV: begin
                    if (w_hit) begin
                        w_next_state = ST_WRITE_COMMIT;
                    end else begin
                        w_next_state = ST_WRITE_RECV;
                    end
                end
                ST_WRITE_COMMIT: w_next_state = ST_DONE;
                ST_DONE:         w_next_state = ST_DONE;
                default:         w_next_state = ST_IDLE;
            endcase
        end
    end

    // Every state change starts the next frame (or an abort) from zero.
    assign w_clear = (w_next_state != r_state);

    edge_counter #(
        .width (countwidth)
    ) u_edge_counter (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_clear),
        .i_en    (w_cnt_en),
        .i_term  (w_term),
        .o_count (w_count),
        .o_hit   (w_hit)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Enables decoded from the state being entered, so they coincide with r_state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr_we   <= 1'b0;
            r_sr_we     <= 1'b0;
            r_dm_we     <= 1'b0;
            r_miso_bufe <= 1'b0;
        end else begin
            r_addr_we   <= (w_next_state == ST_GOT_CMD);
            r_sr_we     <= (w_next_state == ST_READ_LOAD);
            r_dm_we     <= (w_next_state == ST_WRITE_COMMIT);
            r_miso_bufe <= (w_next_state == ST_READ_SEND);
        end
    end

    assign addr_we   = r_addr_we;
    assign sr_we     = r_sr_we;
    assign dm_we     = r_dm_we;
    assign miso_bufe = r_miso_bufe;

`ifdef SPI_FSM_ABORT_FLAG_EN
    logic r_abort;

    // One-cycle pulse after chip select is seen released mid-transaction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_abort <= 1'b0;
        end else begin
            r_abort <= cs_n && in_transaction(r_state);
        end
    end

    assign abort = r_abort;
`endif

endmodule

// File: tb/tb_spi_fsm.sv
// Randomized scoreboard bench for spi_fsm. The stimulus side predicts, from
// the cycle numbers of the frame edges it issues, which enable pulses must
// appear in which cycle; a negedge monitor pops and compares them.
module tb_spi_fsm;

    logic clk = 1'b0;
    logic reset, cs_n, sclk_pos, sclk_neg, rw_bit;
    logic addr_we, sr_we, dm_we, miso_bufe;
    logic abort;
`ifdef SPI_FSM_ABORT_FLAG_EN
    localparam bit ABT_EN = 1'b1;
`else
    localparam bit ABT_EN = 1'b0;
    assign abort = 1'b0;
`endif

    spi_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .cs_n      (cs_n),
        .sclk_pos  (sclk_pos),
        .sclk_neg  (sclk_neg),
        .rw_bit    (rw_bit),
        .addr_we   (addr_we),
        .sr_we     (sr_we),
        .dm_we     (dm_we),
        .miso_bufe (miso_bufe)
`ifdef SPI_FSM_ABORT_FLAG_EN
        ,
        .abort     (abort)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [4:0] V_ADDR = 5'b10000;
    localparam logic [4:0] V_SR   = 5'b01000;
    localparam logic [4:0] V_DM   = 5'b00100;
    localparam logic [4:0] V_MISO = 5'b00010;
    localparam logic [4:0] V_ABT  = 5'b00001;

    typedef struct {
        int         c;
        logic [4:0] v;
    } ev_t;

    ev_t        exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    logic [4:0] mon_v;

    function automatic void push_ev(input int c, input logic [4:0] v);
        ev_t e;
        e.c = c;
        e.v = v;
        exp_q.push_back(e);
    endfunction

    function automatic logic rbit(input int pct);
        return (int'($urandom_range(0, 99)) < pct);
    endfunction

    task automatic cmp(input string name, input logic [4:0] act, input logic [4:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual={addr,sr,dm,miso,abort}=%b required=%b",
                     name, cyc, act, req);
        end
    endtask

    task automatic push_abort(input int c);
        if (ABT_EN) push_ev(c, V_ABT);
    endtask

    // Monitor: any asserted output must match the oldest expected event
    always @(negedge clk) begin
        mon_v = {addr_we, sr_we, dm_we, miso_bufe, abort};
        while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
            checks++;
            failures++;
            $display("FAIL missed_event cycle=%0d actual=none required=%b@%0d",
                     cyc, exp_q[0].v, exp_q[0].c);
            exp_q.delete(0);
        end
        if (mon_v !== 5'b00000) begin
            if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
                cmp("event", mon_v, exp_q[0].v);
                exp_q.delete(0);
            end else begin
                checks++;
                failures++;
                $display("FAIL unexpected_event cycle=%0d actual=%b required=00000",
                         cyc, mon_v);
            end
        end
    end

    task automatic step(input logic cs, input logic p, input logic n);
        @(posedge clk);
        #2;
        cs_n     = cs;
        sclk_pos = p;
        sclk_neg = n;
    endtask

    // Issue n counted edges (pos or neg) with random gaps and opposite-edge
    // noise; optionally raise cs_n together with the abort_at-th edge.
    task automatic frame(input int n, input bit on_neg, input int abort_at,
                         input int rw_final, input bit push_miso,
                         output int last_c, output bit aborted);
        int gap;
        aborted = 1'b0;
        last_c  = cyc;
        for (int k = 1; k <= n; k++) begin
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                if (on_neg) step(1'b0, rbit(50), 1'b0);
                else        step(1'b0, 1'b0, rbit(50));
                if (rw_final >= 0) rw_bit = rbit(50);
                if (push_miso) push_ev(cyc, V_MISO);
            end
            step(k == abort_at, on_neg ? rbit(25) : 1'b1, on_neg ? 1'b1 : rbit(25));
            if (rw_final >= 0) rw_bit = (k == n) ? (rw_final != 0) : rbit(50);
            last_c = cyc;
            if (push_miso) push_ev(cyc, V_MISO);
            if (k == abort_at) begin
                aborted = 1'b1;
                push_abort(cyc + 1);
                break;
            end
        end
    endtask

    // mode 0: complete, 1: abort after j command edges,
    // 2: cs_n rises with j-th data edge, 3: async reset after j read edges
    task automatic txn(input bit is_read, input int mode, input int j);
        int n_c, m_c;
        bit ab;
        repeat ($urandom_range(1, 3)) step(1'b1, rbit(30), rbit(30));
        step(1'b0, 1'b0, 1'b0);
        if (mode == 1) begin
            frame(j, 1'b0, 0, -1, 1'b0, n_c, ab);
            step(1'b1, 1'b0, 1'b0);
            push_abort(cyc + 1);
            step(1'b1, 1'b0, 1'b0);
            return;
        end
        frame(8, 1'b0, 0, is_read ? 1 : 0, 1'b0, n_c, ab);
        push_ev(n_c + 1, V_ADDR);
        if (is_read) begin
            push_ev(n_c + 3, V_SR);
            repeat (3) step(1'b0, rbit(50), rbit(50));
            if (mode == 3) begin
                frame(j, 1'b1, 0, -1, 1'b1, m_c, ab);
                step(1'b0, 1'b0, 1'b0);
                push_ev(cyc, V_MISO);
                #5;
                reset = 1'b1;
                #1;
                cmp("async_reset_outputs", {addr_we, sr_we, dm_we, miso_bufe, abort}, 5'b00000);
                cs_n = 1'b1;
                repeat (2) @(posedge clk);
                #2;
                reset = 1'b0;
                repeat (2) step(1'b1, 1'b0, 1'b0);
                return;
            end
            frame(8, 1'b1, (mode == 2) ? j : 0, -1, 1'b1, m_c, ab);
        end else begin
            step(1'b0, rbit(50), rbit(50));
            frame(8, 1'b0, (mode == 2) ? j : 0, -1, 1'b0, m_c, ab);
            if (!ab) push_ev(m_c + 1, V_DM);
        end
        if (ab) begin
            repeat (2) step(1'b1, 1'b0, 1'b0);
            return;
        end
        repeat (3) begin
            step(1'b0, 1'b1, 1'b1);
            step(1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, rbit(50), rbit(50));
    endtask

    initial begin
        int r, mode, j;
        bit rd;
        reset    = 1'b0;
        cs_n     = 1'b1;
        sclk_pos = 1'b0;
        sclk_neg = 1'b0;
        rw_bit   = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        cmp("reset_state", {addr_we, sr_we, dm_we, miso_bufe, abort}, 5'b00000);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        cmp("idle_after_reset", {addr_we, sr_we, dm_we, miso_bufe, abort}, 5'b00000);

        txn(1'b0, 0, 0);
        txn(1'b1, 0, 0);
        txn(1'b0, 1, 5);
        txn(1'b1, 1, 5);
        txn(1'b0, 2, 8);
        txn(1'b1, 2, 8);
        txn(1'b0, 2, 3);
        txn(1'b1, 3, 4);
        txn(1'b1, 0, 0);
        txn(1'b0, 0, 0);

        for (int t = 0; t < 40; t++) begin
            r  = int'($urandom_range(0, 9));
            rd = rbit(50);
            if (r < 5) begin
                mode = 0; j = 0;
            end else if (r < 7) begin
                mode = 1; j = int'($urandom_range(1, 7));
            end else if (r < 9) begin
                mode = 2; j = int'($urandom_range(1, 8));
            end else begin
                mode = 3; j = int'($urandom_range(1, 7)); rd = 1'b1;
            end
            txn(rd, mode, j);
        end

        repeat (4) step(1'b1, 1'b0, 1'b0);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_events actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
